// File: rtl/riscv_branch_pkg.sv
// Shared types for the branch flush controller: FSM states, 2-bit BHT counters
// and the saturating counter update.
package riscv_branch_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// Interfaces: the BHT access channel between controller and counter array,
// and a bundle of the EX-stage resolve signals for whoever drives the controller.
interface bht_port_if #(
  parameter int IDX_W = 4
);
  logic [IDX_W-1:0]        rd_idx;
  riscv_branch_pkg::ctr_t  rd_ctr;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_taken;

  modport master (output rd_idx, wr_en, wr_idx, wr_taken, input rd_ctr);
  modport slave  (input rd_idx, wr_en, wr_idx, wr_taken, output rd_ctr);
endinterface

interface ex_resolve_if;
  logic        valid;
  logic        branch;
  logic        cond;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] target;
  logic        stall;

  modport master (output valid, branch, cond, pc, pred_taken, target, stall);
  modport slave  (input valid, branch, cond, pc, pred_taken, target, stall);
endinterface

// File: rtl/bht_counter_array.sv
// Array of 2-bit branch history counters: one combinational read port and a
// synchronous saturating-update write port. Reads see the pre-update value.
module bht_counter_array
  import riscv_branch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic      clk,
  input  logic      rst,
  bht_port_if.slave bht
);

  ctr_t mem [ENTRIES];

  assign bht.rd_ctr = mem[bht.rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= CTR_RESET;
    end else if (bht.wr_en) begin
      mem[bht.wr_idx] <= ctr_update(mem[bht.wr_idx], bht.wr_taken);
    end
  end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch direction predictor plus mispredict flush/redirect sequencer.
//   state    | meaning
//   ST_RUN   | resolving branches, updating BHT, no flush
//   ST_FLUSH | squash pipe and redirect PC; held while front end stalls
module branch_flush_ctrl
  import riscv_branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_LSB     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_pc_i,
  output logic        predict_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic        ex_cond_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        stall_i,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  state_t      state, state_nxt;
  logic        taken, resolve, mispredict;
  logic [31:0] redirect_pc_q, redirect_pc_nxt;
  logic [31:0] branch_cnt_q, mispredict_cnt_q;
  logic        unused_bits;

  bht_port_if #(.IDX_W(IDX_W)) bht ();

  bht_counter_array #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk (clk_i),
    .rst (rst_i),
    .bht (bht)
  );

  // Only the index slice of the fetch PC matters to the predictor.
  assign unused_bits = ^fetch_pc_i;

  assign taken      = ex_branch_i & ex_cond_i;
  assign resolve    = (state == ST_RUN) & ex_valid_i & ex_branch_i;
  assign mispredict = resolve & (taken != ex_pred_taken_i);

  assign bht.rd_idx   = fetch_pc_i[IDX_LSB +: IDX_W];
  assign bht.wr_en    = resolve;
  assign bht.wr_idx   = ex_pc_i[IDX_LSB +: IDX_W];
  assign bht.wr_taken = taken;

  assign predict_taken_o  = bht.rd_ctr[1];
  assign redirect_pc_o    = redirect_pc_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_RUN;
      redirect_pc_q    <= 32'h0;
      branch_cnt_q     <= 32'h0;
      mispredict_cnt_q <= 32'h0;
    end else begin
      state         <= state_nxt;
      redirect_pc_q <= redirect_pc_nxt;
      if (resolve)    branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_nxt       = state;
    redirect_pc_nxt = redirect_pc_q;
    flush_o         = 1'b0;
    redirect_o      = 1'b0;
    case (state)
      ST_RUN: begin
        if (mispredict) begin
          state_nxt       = ST_FLUSH;
          redirect_pc_nxt = taken ? ex_target_i : ex_pc_i + 32'd4;
        end
      end
      ST_FLUSH: begin
        flush_o    = 1'b1;
        redirect_o = 1'b1;
        if (!stall_i) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed bench for branch_flush_ctrl: a rule-level model checked every cycle,
// plus hand-computed expectations at the key points of the sequence.
module tb_branch_flush_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict;
  logic        flush, redirect;
  logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ex_resolve_if ex ();

  branch_flush_ctrl #(.BHT_ENTRIES(16), .IDX_LSB(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_pc_i       (fetch_pc),
    .predict_taken_o  (predict),
    .ex_valid_i       (ex.valid),
    .ex_branch_i      (ex.branch),
    .ex_cond_i        (ex.cond),
    .ex_pc_i          (ex.pc),
    .ex_pred_taken_i  (ex.pred_taken),
    .ex_target_i      (ex.target),
    .stall_i          (ex.stall),
    .flush_o          (flush),
    .redirect_o       (redirect),
    .redirect_pc_o    (redirect_pc),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: counters as integers 0..3, flushing as a flag.
  int          m_bht [16];
  bit          m_init = 0;
  bit          m_flush;
  logic [31:0] m_rpc, m_bcnt, m_mcnt;

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1;
      m_flush = 0;
      m_rpc   = 0;
      m_bcnt  = 0;
      m_mcnt  = 0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
    end else if (m_init) begin
      if (m_flush) begin
        if (!ex.stall) m_flush = 0;
      end else if (ex.valid && ex.branch) begin
        int  idx;
        bit  tk;
        tk  = ex.cond;
        idx = int'((ex.pc >> 2) & 32'hF);
        m_bcnt = m_bcnt + 1;
        if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        if (tk != ex.pred_taken) begin
          m_mcnt  = m_mcnt + 1;
          m_flush = 1;
          m_rpc   = tk ? ex.target : ex.pc + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_predict", {31'b0, predict},
          {31'b0, (m_bht[int'((fetch_pc >> 2) & 32'hF)] >= 2)});
      chk("cmp_flush",    {31'b0, flush},    {31'b0, m_flush});
      chk("cmp_redirect", {31'b0, redirect}, {31'b0, m_flush});
      chk("cmp_rpc",      redirect_pc,       m_rpc);
      chk("cmp_bcnt",     branch_cnt,        m_bcnt);
      chk("cmp_mcnt",     mispredict_cnt,    m_mcnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic c, input logic [31:0] pc,
                       input logic p, input logic [31:0] t);
    ex.valid      = v;
    ex.branch     = b;
    ex.cond       = c;
    ex.pc         = pc;
    ex.pred_taken = p;
    ex.target     = t;
  endtask

  initial begin
    rst      = 1'b1;
    fetch_pc = 32'h100;
    ex.stall = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_predict", {31'b0, predict}, 32'd0);
    chk("rst_bcnt", branch_cnt, 32'd0);
    chk("rst_mcnt", mispredict_cnt, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);

    // Taken branch predicted not-taken: flush to target. Inputs held during FLUSH are ignored.
    drive(1, 1, 1, 32'h40, 0, 32'h80);
    step();
    chk("mp1_flush", {31'b0, flush}, 32'd1);
    chk("mp1_redirect", {31'b0, redirect}, 32'd1);
    chk("mp1_rpc", redirect_pc, 32'h80);
    chk("mp1_mcnt", mispredict_cnt, 32'd1);
    chk("mp1_bcnt", branch_cnt, 32'd1);
    step();
    ex.valid = 1'b0;
    #1;
    chk("mp1_run", {31'b0, flush}, 32'd0);
    chk("mp1_ignored", branch_cnt, 32'd1);

    // Two correctly predicted taken resolves saturate the counter.
    fetch_pc = 32'h40;
    drive(1, 1, 1, 32'h40, 1, 32'h80);
    step();
    chk("ok1_flush", {31'b0, flush}, 32'd0);
    step();
    ex.valid = 1'b0;
    #1;
    chk("ok2_flush", {31'b0, flush}, 32'd0);
    chk("ok2_predict", {31'b0, predict}, 32'd1);
    chk("ok2_bcnt", branch_cnt, 32'd3);
    chk("ok2_mcnt", mispredict_cnt, 32'd1);

    // Non-branch and invalid instructions change nothing.
    drive(1, 0, 1, 32'h40, 0, 32'h80);
    step();
    drive(0, 1, 0, 32'h40, 1, 32'h0);
    step();
    ex.valid = 1'b0;
    #1;
    chk("nb_bcnt", branch_cnt, 32'd3);
    chk("nb_flush", {31'b0, flush}, 32'd0);

    // Same index read and written in one cycle: read sees the old value.
    drive(1, 1, 0, 32'h40, 1, 32'h80);
    #1;
    chk("byp_predict", {31'b0, predict}, 32'd1);
    step();
    chk("nt_flush", {31'b0, flush}, 32'd1);
    chk("nt_rpc", redirect_pc, 32'h44);
    ex.valid = 1'b0;
    step();
    drive(1, 1, 0, 32'h40, 1, 32'h80);
    step();
    ex.valid = 1'b0;
    step();
    chk("nt2_predict", {31'b0, predict}, 32'd0);
    chk("nt2_bcnt", branch_cnt, 32'd5);
    chk("nt2_mcnt", mispredict_cnt, 32'd3);

    // Not-taken mispredict at the top of memory, held by 3 stall cycles.
    ex.stall = 1'b1;
    drive(1, 1, 0, 32'hFFFF_FFFC, 1, 32'h1234);
    step();
    ex.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex.stall = (i < 3);
      #1;
      chk("stall_flush", {31'b0, flush}, 32'd1);
      chk("stall_rpc", redirect_pc, 32'h0);
      step();
    end
    chk("stall_done", {31'b0, flush}, 32'd0);
    chk("stall_mcnt", mispredict_cnt, 32'd4);
    chk("stall_bcnt", branch_cnt, 32'd6);

    // Reset during an active FLUSH.
    ex.stall = 1'b1;
    drive(1, 1, 1, 32'h80, 0, 32'h200);
    step();
    ex.valid = 1'b0;
    #1;
    chk("rf_flush_on", {31'b0, flush}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rf_flush", {31'b0, flush}, 32'd0);
    chk("rf_redirect", {31'b0, redirect}, 32'd0);
    chk("rf_predict", {31'b0, predict}, 32'd0);
    chk("rf_bcnt", branch_cnt, 32'd0);
    chk("rf_rpc", redirect_pc, 32'd0);

    // Reset coinciding with a mispredict detection.
    drive(1, 1, 1, 32'h80, 0, 32'h200);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    ex.valid = 1'b0;
    #1;
    chk("rp_flush", {31'b0, flush}, 32'd0);
    chk("rp_mcnt", mispredict_cnt, 32'd0);

    ex.stall = 1'b0;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
